// File: rtl/dsram_like_responder_pkg.sv
// Purpose : shared definitions for the data-side SRAM-like responder.
// Latency : n/a (types, constants and a pure helper function only).
// Backpr. : n/a.
// Contents: access-size encodings, LATENCY bounds, countdown width, and the
//           stall LFSR seed/taps/step function used when DSRAM_RANDOM_STALL_EN is defined.
package dsram_like_responder_pkg;

    // Access size encodings carried on size_i. The responder serves every
    // access as a full word, so these are informational for callers.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Legal range for the accept-to-response latency.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;

    // Countdown field width; holds LATENCY-1 for any legal LATENCY.
    localparam int CD_W = $clog2(LATENCY_MAX + 1);

    // Stall-injection LFSR: 16-bit Galois, x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ ({16{s[0]}} & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/dsram_like_responder_resp_fifo.sv
// Purpose : ordered response queue; every entry carries its own countdown to due.
// Latency : an entry pushed with countdown LATENCY-1 is due LATENCY-1 cycles later.
// Backpr. : caller must not push when count_o == DEPTH; pop only when due_o.
// Ports   : clk/rst (sync, active-high); push_i/push_wr_i/push_dat_i enqueue;
//           pop_i dequeues head; due_o/head_wr_o/head_dat_o describe head;
//           count_o is the number of valid entries.
module dsram_resp_fifo
    import dsram_like_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             push_wr_i,
    input  logic [31:0]      push_dat_i,
    input  logic             pop_i,
    output logic             due_o,
    output logic             head_wr_o,
    output logic [31:0]      head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CD_W-1:0]  cd_q  [DEPTH];
    logic [CD_W-1:0]  cd_d  [DEPTH];
    logic             wr_q  [DEPTH];
    logic             wr_d  [DEPTH];
    logic [31:0]      dat_q [DEPTH];
    logic [31:0]      dat_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        vld_d    = vld_q;
        cd_d     = cd_q;
        wr_d     = wr_q;
        dat_d    = dat_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        // Every waiting entry ages, not just the head, so an entry that
        // reaches the head is already due if its time has passed.
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (cd_q[i] != '0)) begin
                cd_d[i] = cd_q[i] - 1'b1;
            end
        end

        if (pop_i) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end

        // Push never targets the slot being popped: a push implies the queue
        // is not full, so the write slot differs from a valid head slot.
        if (push_i) begin
            vld_d[wr_ptr_q] = 1'b1;
            cd_d[wr_ptr_q]  = CD_W'(LATENCY - 1);
            wr_d[wr_ptr_q]  = push_wr_i;
            dat_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload and countdowns need no reset; they are qualified by vld_q.
    always_ff @(posedge clk) begin
        cd_q  <= cd_d;
        wr_q  <= wr_d;
        dat_q <= dat_d;
    end

    assign due_o      = vld_q[rd_ptr_q] && (cd_q[rd_ptr_q] == '0);
    assign head_wr_o  = wr_q[rd_ptr_q];
    assign head_dat_o = dat_q[rd_ptr_q];
    assign count_o    = cnt_q;

endmodule

// File: rtl/dsram_like_responder.sv
// Purpose : SRAM-like data-side responder: byte-lane word array plus in-order response queue.
// Latency : data_ok_o exactly LATENCY cycles after the accept cycle, responses in accept order.
// Backpr. : addr_ok_o drops while MAX_OUTS requests are outstanding (or on injected stall).
// Ports   : clk, rst (sync, active-high); req_i/wr_i/size_i/wstrb_i/addr_i/wdata_i request;
//           addr_ok_o accept strobe; data_ok_o/rdata_o response (rdata 0 for stores).
// Config  : define DSRAM_RANDOM_STALL_EN to inject LFSR-driven accept stalls.
module dsram_like_responder
    import dsram_like_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int MAX_OUTS    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    widx;
    logic [31:0]      rd_word;
    logic             stall;
    logic             accept;
    logic             room;
    logic             head_due;
    logic             head_wr;
    logic [31:0]      head_dat;
    logic [CNT_W-1:0] outs_cnt;

    // Size and byte offset never change the access; upper address bits alias.
    logic unused_bits;
    assign unused_bits = ^{size_i, addr_i[31:AW+2], addr_i[1:0]};

    assign widx = addr_i[AW+1:2];

`ifdef DSRAM_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Stall only gates new accepts; due responses still retire.
    assign stall = lfsr_q[0] & lfsr_q[3];
`else
    assign stall = 1'b0;
`endif

    // The count seen here is pre-pop, so a retiring response does not open
    // a slot for an accept in the same cycle.
    assign room      = (outs_cnt < CNT_W'(MAX_OUTS));
    assign addr_ok_o = ~rst & req_i & room & ~stall;
    assign accept    = addr_ok_o;

    // Word array with per-byte write enables; asynchronous read so a load
    // captures the word present at its accept edge.
    always_ff @(posedge clk) begin
        if (accept && wr_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem[widx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];

    dsram_resp_fifo #(
        .DEPTH   (MAX_OUTS),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_wr_i  (wr_i),
        .push_dat_i (wr_i ? 32'h0 : rd_word),
        .pop_i      (data_ok_o),
        .due_o      (head_due),
        .head_wr_o  (head_wr),
        .head_dat_o (head_dat),
        .count_o    (outs_cnt)
    );

    assign data_ok_o = ~rst & head_due;
    assign rdata_o   = (data_ok_o && !head_wr) ? head_dat : 32'h0;

endmodule

// File: tb/tb_dsram_like_responder.sv
module tb_dsram_like_responder;

    localparam int NI          = 3;
    localparam int LAT_A [NI]  = '{2, 1, 3};
    localparam int MO_A  [NI]  = '{2, 4, 2};
    localparam int DEP_A [NI]  = '{1024, 64, 64};
    localparam int MAXB        = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok [NI];
    logic        dok [NI];
    logic [31:0] rd  [NI];

    always #5 clk = ~clk;

    // Three configurations share one stimulus stream; each has its own model.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        dsram_like_responder #(
            .DEPTH_WORDS (DEP_A[g]),
            .LATENCY     (LAT_A[g]),
            .MAX_OUTS    (MO_A[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_i     (req),
            .wr_i      (wr),
            .size_i    (size),
            .wstrb_i   (strb),
            .addr_i    (addr),
            .wdata_i   (wdata),
            .addr_ok_o (aok[g]),
            .data_ok_o (dok[g]),
            .rdata_o   (rd[g])
        );
    end

    // Behavioural model: pending responses with absolute due cycle, byte memory.
    typedef struct {
        longint      due;
        logic [31:0] dat;
        logic [31:0] msk;
    } exp_t;

    exp_t        ring [NI][8];
    int          hd   [NI];
    int          cnt  [NI];
    logic [7:0]  mb   [NI][MAXB];
    bit          kn   [NI][MAXB];
    longint      cyc;
    int          checks;
    int          errors;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %h want %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            bit   e_aok;
            bit   e_dok;
            bit   acc;
            int   idx;
            exp_t e;
            e_aok = !rst && req && (cnt[k] < MO_A[k]);
`ifdef DSRAM_RANDOM_STALL_EN
            chk("addr_ok_over_limit", k, {31'b0, aok[k] & ~e_aok}, 32'h0);
            acc = aok[k] && e_aok;
`else
            chk("addr_ok", k, {31'b0, aok[k]}, {31'b0, e_aok});
            acc = e_aok;
`endif
            e_dok = !rst && (cnt[k] > 0) && (ring[k][hd[k]].due == cyc);
            chk("data_ok", k, {31'b0, dok[k]}, {31'b0, e_dok});
            if (rst) begin
                chk("rdata_in_reset", k, rd[k], 32'h0);
            end else if (e_dok && dok[k]) begin
                e = ring[k][hd[k]];
                chk("rdata", k, rd[k] & e.msk, e.dat & e.msk);
            end
            if (rst) begin
                hd[k]  = 0;
                cnt[k] = 0;
            end else begin
                if (e_dok) begin
                    hd[k]  = (hd[k] + 1) % 8;
                    cnt[k] = cnt[k] - 1;
                end
                if (acc) begin
                    idx   = int'((addr >> 2) % DEP_A[k]);
                    e.due = cyc + LAT_A[k];
                    e.dat = 32'h0;
                    e.msk = 32'hFFFF_FFFF;
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb[b]) begin
                                mb[k][idx*4+b] = wdata[8*b +: 8];
                                kn[k][idx*4+b] = 1'b1;
                            end
                        end
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            e.dat[8*b +: 8] = mb[k][idx*4+b];
                            e.msk[8*b +: 8] = kn[k][idx*4+b] ? 8'hFF : 8'h00;
                        end
                    end
                    ring[k][(hd[k] + cnt[k]) % 8] = e;
                    cnt[k] = cnt[k] + 1;
                end
            end
        end
        cyc++;
    endtask

    // Apply one cycle of inputs just after the edge, then check at negedge.
    task automatic step(input bit r, input bit rq, input bit w, input logic [1:0] sz,
                        input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst   = r;
        req   = rq;
        wr    = w;
        size  = sz;
        strb  = st;
        addr  = a;
        wdata = d;
        @(negedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, 2'd2, 4'h0, a, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input logic [1:0] sz);
        step(1'b0, 1'b1, 1'b1, sz, st, a, d);
    endtask

    initial begin
        bit ea [6];
        bit ed [6];
        rst    = 1'b1;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        strb   = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        cyc    = 0;
        checks = 0;
        errors = 0;

        // Reset with a request pending: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0);
            for (int k = 0; k < NI; k++) chk("reset_addr_ok", k, {31'b0, aok[k]}, 32'h0);
        end
        idle(1);

`ifndef DSRAM_RANDOM_STALL_EN
        // Store then load at 0x1000.
        store(32'h1000, 32'hDEADBEEF, 4'hF, 2'd2);
        chk("st_accept", 0, {31'b0, aok[0]}, 32'h1);
        load(32'h1000);
        chk("ld_accept", 0, {31'b0, aok[0]}, 32'h1);
        chk("l2_not_early", 0, {31'b0, dok[0]}, 32'h0);
        chk("l1_store_resp", 1, {31'b0, dok[1]}, 32'h1);
        idle(1);
        chk("l2_store_resp", 0, {31'b0, dok[0]}, 32'h1);
        chk("l2_store_rdata", 0, rd[0], 32'h0);
        chk("l1_load_data", 1, rd[1], 32'hDEADBEEF);
        idle(1);
        chk("l2_load_resp", 0, {31'b0, dok[0]}, 32'h1);
        chk("l2_load_data", 0, rd[0], 32'hDEADBEEF);
        chk("l3_store_resp", 2, {31'b0, dok[2]}, 32'h1);
        idle(1);
        chk("l3_load_data", 2, rd[2], 32'hDEADBEEF);
        idle(2);

        // Partial-lane merge with a misaligned byte-size store.
        store(32'h2000, 32'h11223344, 4'hF, 2'd2);
        idle(3);
        store(32'h2001, 32'h0000AA00, 4'b0010, 2'd0);
        idle(3);
        load(32'h2000);
        idle(1);
        chk("l1_merge_data", 1, rd[1], 32'h1122AA44);
        idle(1);
        chk("l2_merge_resp", 0, {31'b0, dok[0]}, 32'h1);
        chk("l2_merge_data", 0, rd[0], 32'h1122AA44);
        idle(3);

        // Request held high against MAX_OUTS=2, LATENCY=3.
        ea = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            load(32'h2000);
            chk("l3_hold_addr_ok", 2, {31'b0, aok[2]}, {31'b0, ea[i]});
            chk("l3_hold_data_ok", 2, {31'b0, dok[2]}, {31'b0, ed[i]});
        end
        idle(6);

        // Four back-to-back loads at LATENCY=1.
        for (int i = 0; i < 4; i++) begin
            store(32'(i * 4), 32'hA0A0_0000 + 32'(i), 4'hF, 2'd2);
            idle(3);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) load(32'(i * 4));
            else idle(1);
            if (i > 0) begin
                chk("l1_stream_data_ok", 1, {31'b0, dok[1]}, 32'h1);
                chk("l1_stream_data", 1, rd[1], 32'hA0A0_0000 + 32'(i - 1));
            end
        end
        idle(6);

        // Reset while two loads are in flight.
        load(32'h2000);
        chk("pre_rst_accept0", 0, {31'b0, aok[0]}, 32'h1);
        load(32'h2000);
        chk("pre_rst_accept1", 0, {31'b0, aok[0]}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 32'h2000, 32'h0);
        chk("rst_pulse_addr_ok", 0, {31'b0, aok[0]}, 32'h0);
        chk("rst_pulse_data_ok", 0, {31'b0, dok[0]}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            for (int k = 0; k < NI; k++) chk("post_rst_no_resp", k, {31'b0, dok[k]}, 32'h0);
        end
        load(32'h2000);
        chk("post_rst_accept", 0, {31'b0, aok[0]}, 32'h1);
        idle(6);
`endif

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 1200; n++) begin
            bit          r;
            bit          rq;
            bit          w;
            logic [1:0]  sz;
            logic [3:0]  st;
            logic [31:0] a;
            r  = ($urandom_range(0, 249) == 0);
            rq = ($urandom_range(0, 9) < 7);
            w  = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            st = 4'($urandom_range(0, 15));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            step(r, rq, w, sz, st, a, $urandom);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsram_like_responder.md
DSRAM_LIKE_RESPONDER -- requirements
Module: dsram_like_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, word count of internal data array (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request accept to data_ok_o, legal 1..7.
REQ-003 Parameter MAX_OUTS, default 2, maximum outstanding accepted-but-unanswered requests.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i  in  1  CPU data-side request valid.
REQ-007 wr_i  in  1  1 = store, 0 = load.
REQ-008 size_i  in  2  0 = byte, 1 = half, 2 = word.
REQ-009 wstrb_i  in  4  byte-lane write enables, store only.
REQ-010 addr_i  in  32  byte address.
REQ-011 wdata_i  in  32  store data, lane-aligned.
REQ-012 addr_ok_o  out  1  request accepted this cycle.
REQ-013 data_ok_o  out  1  one response completes this cycle.
REQ-014 rdata_o  out  32  full aligned word for loads; valid only with data_ok_o.

Function
REQ-015 addr_ok_o SHALL equal req_i & (outstanding < MAX_OUTS) & ~stall; stall is 0 unless REQ-030 applies.
REQ-016 Accept = req_i & addr_ok_o; a pop in the same cycle SHALL NOT free a slot for that cycle's accept.
REQ-017 Word index SHALL be addr_i[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliasing).
REQ-018 Store SHALL write the array at the accept edge, byte lanes per wstrb_i only; size_i and addr_i[1:0] do not alter the write.
REQ-019 Load SHALL capture the array word at the accept edge into its response entry; later stores do not change it.
REQ-020 Misaligned size/addr combinations SHALL be accepted and served as word accesses; no error signalled.
REQ-021 Each accepted request SHALL enqueue {wr, data, countdown = LATENCY-1}; nonzero countdowns decrement every cycle, including while not at head.
REQ-022 data_ok_o SHALL be 1 exactly when head entry is valid with countdown 0; head pops that cycle; at most one response per cycle.
REQ-023 Responses SHALL return strictly in accept order.
REQ-024 rdata_o SHALL present the head entry data for loads and 32'h0 for stores.
REQ-025 With LATENCY=1 and no backlog, data_ok_o SHALL assert in the cycle immediately following the accept edge.
REQ-026 Back-to-back accepts with LATENCY=1 SHALL sustain one response per cycle.

Reset
REQ-027 While rst=1: outstanding count 0, queue invalid, addr_ok_o 0, data_ok_o 0, rdata_o 0.
REQ-028 Reset mid-operation SHALL discard all outstanding entries; no data_ok_o for them afterwards; array contents not reset.

Configuration
REQ-029 Macro DSRAM_RANDOM_STALL_EN selects stall injection.
REQ-030 Defined: a 16-bit LFSR (seed 16'hACE1 at reset, advances every cycle) drives stall = lfsr[0]&lfsr[3]; stall blocks addr_ok_o only, never delays due responses.
REQ-031 Undefined: stall tied 0, no LFSR logic present.

Structure
REQ-032 Shared package SHALL hold size encodings (BYTE/HALF/WORD), LATENCY bounds, LFSR seed and taps.
REQ-033 Sub-module dsram_resp_fifo SHALL implement the MAX_OUTS-entry ordered response queue with per-entry countdowns.
REQ-034 Data array SHALL be inferred RAM with per-byte write enables in the top module.

Verification
REQ-035 LATENCY=2: store 0x1000, wstrb 4'hF, data 0xDEADBEEF; then load 0x1000 -> second data_ok_o carries rdata_o 0xDEADBEEF, 2 cycles after its accept.
REQ-036 Store 0x2000 data 0x11223344 strb 4'hF, then store 0x2001 data 0x0000AA00 strb 4'b0010 -> load 0x2000 returns 0x1122AA44.
REQ-037 MAX_OUTS=2, req_i held high, LATENCY=3 -> addr_ok_o 1,1,0 then re-asserts only the cycle after first data_ok_o; order preserved.
REQ-038 LATENCY=1, 4 consecutive loads 0x0,0x4,0x8,0xC -> data_ok_o high 4 consecutive cycles, data in address order.
REQ-039 Two loads accepted, rst pulsed 1 cycle before first due -> no data_ok_o, addr_ok_o 0 during reset, count 0 after.
REQ-040 With DSRAM_RANDOM_STALL_EN, 1000 random accesses vs scoreboard -> all data match, each response exactly LATENCY cycles after accept when no backlog.
